dmem_mmio_responder: RTL and testbench



---
 rtl/dmem_mmio_responder.sv | 118 +++++++++++
 tb/tb_dmem_mmio_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory bus responder that passes low addresses to dmem
// and decodes the top of the word space into a TX FIFO, a FIFO status register and a cycle counter.
`default_nettype none

module dmem_mmio_responder #(
   parameter int                ADDR_W     = 12,
   parameter int                DATA_W     = 32,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hF00
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address_dmem,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic [DATA_W-1:0] q_dmem,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] OFF_TXDATA = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] OFF_CYCLES = ADDR_W'(2);
   localparam logic [4:0]        DEPTH_CNT  = 5'(FIFO_DEPTH);

   logic              mmio;
   logic [ADDR_W-1:0] offset;
   logic              sel_tx, sel_st, sel_cyc;
   logic              push_req, push_ok, pop, full, empty;
   logic [DATA_W-1:0] status_val;

   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [4:0]        count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] cycles_q, cycles_d;
   logic              sel_mmio_q;
   logic [DATA_W-1:0] local_q, local_d;
   logic              rst_q;
   logic [DATA_W-1:0] buf_q [FIFO_DEPTH];

   assign mmio     = (address_dmem >= MMIO_BASE);
   assign offset   = address_dmem - MMIO_BASE;
   assign sel_tx   = mmio && (offset == OFF_TXDATA);
   assign sel_st   = mmio && (offset == OFF_STATUS);
   assign sel_cyc  = mmio && (offset == OFF_CYCLES);
   assign mem_wren = wren & ~mmio & ~reset;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == 5'd0);
   assign tx_valid = ~empty;
   assign tx_data  = buf_q[rd_ptr_q];
   assign pop      = tx_valid & tx_ready;
   assign push_req = wren & sel_tx;
   // A pop frees the slot the push needs, so a full FIFO still accepts it.
   assign push_ok  = push_req & (~full | pop);

   // Layout: overflow at bit 6, empty at bit 5, count in [4:0]; full is count == depth.
   assign status_val = DATA_W'({overflow_q, empty, count_q});

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      cycles_d   = cycles_q + DATA_W'(1);
      local_d    = '0;

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + 5'd1;
      else if (!push_ok && pop) count_d = count_q - 5'd1;

      if (push_req && full && !pop)       overflow_d = 1'b1;
      else if (wren && sel_st && data[6]) overflow_d = 1'b0;

      if (wren && sel_cyc) cycles_d = data;

      if (sel_st)       local_d = status_val;
      else if (sel_cyc) local_d = cycles_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         cycles_q   <= '0;
         sel_mmio_q <= 1'b0;
         local_q    <= '0;
         rst_q      <= 1'b1;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cycles_q   <= cycles_d;
         sel_mmio_q <= mmio;
         local_q    <= local_d;
         rst_q      <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok && !reset) buf_q[wr_ptr_q] <= data;
   end

   // Any read in flight across a reset edge is discarded and returns zero.
   assign q_dmem = rst_q ? '0 : (sel_mmio_q ? local_q : mem_q);

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed self-checking bench for dmem_mmio_responder.
`default_nettype none

module tb_dmem_mmio_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        mem_wren;
   logic [31:0] mem_q;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_cmp = 0;
   int n_err = 0;

   dmem_mmio_responder #(
      .ADDR_W(12), .DATA_W(32), .FIFO_DEPTH(8), .MMIO_BASE(12'hF00)
   ) dut (
      .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
      .wren(wren), .q_dmem(q_dmem), .mem_wren(mem_wren), .mem_q(mem_q),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      address_dmem = 12'hF00; data = v; wren = 1'b1;
      cyc();
      wren = 1'b0; address_dmem = 12'h000;
   endtask

   task automatic test_reset();
      reset = 1'b1; address_dmem = 12'h010; data = 32'h0; wren = 1'b1;
      mem_q = 32'h12345678; tx_ready = 1'b0;
      #1;
      n_cmp++;
      if (mem_wren !== 1'b0) begin n_err++; $display("FAIL reset_mem_wren: got %b want 0", mem_wren); end
      cyc(); cyc();
      wren = 1'b0; address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h0) begin n_err++; $display("FAIL reset_q_dmem: got %h want 00000000", q_dmem); end
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      reset = 1'b0;
      // Release cycle plus five idle cycles: six counting edges before the read.
      for (int i = 0; i < 6; i++) begin
         cyc();
         n_cmp++;
         if (tx_valid !== 1'b0) begin n_err++; $display("FAIL idle_tx_valid: got %b want 0 at %0d", tx_valid, i); end
      end
      address_dmem = 12'hF02;
      cyc();
      address_dmem = 12'hF01;
      n_cmp++;
      if (q_dmem !== 32'd6) begin n_err++; $display("FAIL cycles_after_reset: got %h want 00000006", q_dmem); end
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h20) begin n_err++; $display("FAIL status_empty: got %h want 00000020", q_dmem); end
   endtask

   task automatic test_passthrough();
      address_dmem = 12'h010; data = 32'hDEADBEEF; wren = 1'b1;
      #1;
      n_cmp++;
      if (mem_wren !== 1'b1) begin n_err++; $display("FAIL pass_mem_wren: got %b want 1", mem_wren); end
      cyc();
      wren = 1'b0; mem_q = 32'hDEADBEEF;
      cyc();
      n_cmp++;
      if (q_dmem !== 32'hDEADBEEF) begin n_err++; $display("FAIL pass_read: got %h want deadbeef", q_dmem); end
      address_dmem = 12'hEFF; wren = 1'b1;
      #1;
      n_cmp++;
      if (mem_wren !== 1'b1) begin n_err++; $display("FAIL below_base_wren: got %b want 1", mem_wren); end
      address_dmem = 12'hF05; data = 32'hFFFFFFFF;
      #1;
      n_cmp++;
      if (mem_wren !== 1'b0) begin n_err++; $display("FAIL mmio_wren: got %b want 0", mem_wren); end
      cyc();
      wren = 1'b0; address_dmem = 12'hF05;
      cyc();
      n_cmp++;
      if (q_dmem !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 00000000", q_dmem); end
      address_dmem = 12'hF01;
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h20 || tx_valid !== 1'b0) begin
         n_err++; $display("FAIL f05_no_effect: status %h valid %b want 00000020 0", q_dmem, tx_valid);
      end
   endtask

   task automatic test_fill();
      tx_ready = 1'b0;
      for (int v = 1; v <= 9; v++) push(32'(v));
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 32'd1) begin
         n_err++; $display("FAIL fill_head: valid %b data %h want 1 00000001", tx_valid, tx_data);
      end
      address_dmem = 12'hF01;
      cyc();
      n_cmp++;
      if (q_dmem !== 32'h48) begin n_err++; $display("FAIL fill_status: got %h want 00000048", q_dmem); end
      data = 32'h40; wren = 1'b1;
      cyc();
      wren = 1'b0;
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h08) begin n_err++; $display("FAIL overflow_clear: got %h want 00000008", q_dmem); end
   endtask

   task automatic test_drain();
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         n_cmp++;
         if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin
            n_err++; $display("FAIL drain_seq: valid %b data %h want 1 %h", tx_valid, tx_data, 32'(i));
         end
         cyc();
      end
      tx_ready = 1'b0;
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
      address_dmem = 12'hF01;
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h20) begin n_err++; $display("FAIL drain_status: got %h want 00000020", q_dmem); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i));
      tx_ready = 1'b1;
      repeat (3) cyc();
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'hB0 + 32'(i));
      address_dmem = 12'hF01;
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h08) begin n_err++; $display("FAIL wrap_status: got %h want 00000008", q_dmem); end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (tx_valid !== 1'b1 || tx_data !== 32'hB0 + 32'(i)) begin
            n_err++; $display("FAIL wrap_seq: valid %b data %h want 1 %h", tx_valid, tx_data, 32'hB0 + 32'(i));
         end
         cyc();
      end
      tx_ready = 1'b0;
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", tx_valid); end
   endtask

   task automatic test_push_pop_full();
      for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
      address_dmem = 12'hF00; data = 32'hCF; wren = 1'b1; tx_ready = 1'b1;
      n_cmp++;
      if (tx_data !== 32'hC0) begin n_err++; $display("FAIL pp_head: got %h want 000000c0", tx_data); end
      cyc();
      wren = 1'b0; tx_ready = 1'b0; address_dmem = 12'hF01;
      cyc();
      n_cmp++;
      if (q_dmem !== 32'h08) begin n_err++; $display("FAIL pp_status: got %h want 00000008", q_dmem); end
      // STATUS sampled on a popping edge reports the pre-pop count.
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         logic [31:0] exp_v;
         exp_v = (i == 8) ? 32'hCF : 32'hC0 + 32'(i);
         n_cmp++;
         if (tx_valid !== 1'b1 || tx_data !== exp_v) begin
            n_err++; $display("FAIL pp_seq: valid %b data %h want 1 %h", tx_valid, tx_data, exp_v);
         end
         cyc();
         if (i == 1) begin
            address_dmem = 12'h000;
            n_cmp++;
            if (q_dmem !== 32'h08) begin n_err++; $display("FAIL pre_pop_status: got %h want 00000008", q_dmem); end
         end
      end
      tx_ready = 1'b0;
      n_cmp++;
      if (tx_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b want 0", tx_valid); end
   endtask

   task automatic test_cycles_wrap();
      logic [31:0] exp_v [3];
      exp_v[0] = 32'hFFFFFFFE; exp_v[1] = 32'hFFFFFFFF; exp_v[2] = 32'h00000000;
      address_dmem = 12'hF02; data = 32'hFFFFFFFE; wren = 1'b1;
      cyc();
      wren = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if (q_dmem !== exp_v[i]) begin n_err++; $display("FAIL cycles_wrap: got %h want %h", q_dmem, exp_v[i]); end
      end
      address_dmem = 12'h000;
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
      tx_ready = 1'b1;
      cyc();
      n_cmp++;
      if (tx_data !== 32'hD1) begin n_err++; $display("FAIL pre_reset_head: got %h want 000000d1", tx_data); end
      reset = 1'b1; address_dmem = 12'hF01;
      cyc();
      n_cmp++;
      if (tx_valid !== 1'b0 || q_dmem !== 32'h0) begin
         n_err++; $display("FAIL mid_reset: valid %b q %h want 0 00000000", tx_valid, q_dmem);
      end
      reset = 1'b0; tx_ready = 1'b0;
      cyc();
      address_dmem = 12'h000;
      n_cmp++;
      if (q_dmem !== 32'h20 || tx_valid !== 1'b0) begin
         n_err++; $display("FAIL post_reset_status: q %h valid %b want 00000020 0", q_dmem, tx_valid);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_fill();
      test_drain();
      test_wrap();
      test_push_pop_full();
      test_cycles_wrap();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
